seq_detect_arbiter: RTL and testbench
=====================================

Name: seq_detect_arbiter

Overview:
- Shares one serial pattern-matching engine between NUM_REQ requesters.
- Each requester presents a WORD_W-bit word. A round-robin arbiter grants one requester per frame.
- The granted word is shifted MSB-first, one bit per clock, through the matcher, which counts occurrences of PATTERN (overlapping allowed).
- Per-frame result (channel, match count) is returned over a valid/ready handshake. Sits between the serial-data sources and the downstream result consumer.

Parameters:
- NUM_REQ, 4: number of requester channels (2..16).
- WORD_W, 8: bits per frame.
- PAT_LEN, 4: pattern length in bits; elaboration error if PAT_LEN > WORD_W or PAT_LEN < 1.
- PATTERN, 4'b1011: pattern to detect, MSB compared against the oldest bit.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- req  input  NUM_REQ  per-channel request; held high with word valid until acked.
- word_in  input  NUM_REQ*WORD_W  channel i word at bits [i*WORD_W +: WORD_W].
- ack  output  NUM_REQ  one-hot, single-cycle pulse; word of that channel captured this edge.
- busy  output  1  high whenever state is not IDLE.
- res_valid  output  1  frame result available.
- res_ready  input  1  consumer accepts result.
- res_chan  output  clog2(NUM_REQ)  channel index of the result.
- res_count  output  clog2(WORD_W+1)  matches found in the frame.

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE, rr pointer 0, shift register 0, matcher cleared.
  - ack 0, busy 0, res_valid 0, res_chan 0, res_count 0.
- Reset mid-frame aborts the frame. No result is produced and no ack is repeated.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - If any req is high, the arbiter selects the first requesting channel at or after the rr pointer, wrapping modulo NUM_REQ.
  - ack[sel] is high combinationally in that cycle.
  - At the edge: word captured, res_chan <= sel, rr pointer <= (sel+1) mod NUM_REQ, matcher cleared, state -> SHIFT.
  - If no req is high, stay in IDLE with ack = 0.
- SHIFT:
  - Runs exactly WORD_W cycles. Each cycle feeds the shift register MSB into the matcher, then shifts left.
  - Bit counter runs 0..WORD_W-1. On the last bit, state -> REPORT.
  - req is ignored during SHIFT.
- Matcher:
  - Keeps the last PAT_LEN bits of the current frame only; history is cleared at frame start, so no cross-frame matches.
  - Compares against PATTERN once at least PAT_LEN bits of the frame have been fed.
  - Increments count on each match; overlapping matches count.
  - Count never exceeds WORD_W-PAT_LEN+1, so no overflow is possible.
- REPORT:
  - res_valid = 1, and res_chan and res_count are stable.
  - On res_valid & res_ready at the edge: state -> IDLE, res_valid falls.
  - res_count and res_chan hold their values until the next frame.
  - res_ready while not valid is ignored.
- Latency:
  - ack cycle to res_valid = WORD_W+1 edges.
  - Minimum spacing between acks = WORD_W+2 cycles, because of the one IDLE cycle after acceptance.
- Fairness: a continuously requesting channel waits at most NUM_REQ-1 frames.
- Request dropped before ack: never granted, no side effect.

Optional Feature:
- Macro: SEQ_DETECT_ARBITER_STATS_EN.
- Defined:
  - Adds output stat_frames[15:0], incremented on each accepted result (res_valid & res_ready).
  - Adds output stat_matches[15:0], incremented by res_count on each accepted result.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package seq_arb_pkg:
  - FSM state enum (IDLE, SHIFT, REPORT).
  - Default PATTERN and PAT_LEN constants.
  - Stats counter width constant (16).
- Sub-module seq_match_core:
  - Inputs: clock, reset, clear, bit_valid, bit_in.
  - Output: count.
  - Parameters: PATTERN, PAT_LEN, WORD_W.
- Arbiter and FSM stay in the top module.

Test Plan:
- Single channel: req[0]=1, word 8'b10110110.
  - Expect ack[0] for one cycle.
  - res_valid 9 edges later with res_chan=0, res_count=2 (overlap at bit 3).
- No-match and edge words:
  - word 8'hFF -> res_count=0.
  - word 8'h00 -> res_count=0.
  - word 8'b00001011 -> res_count=1 (match on the final bit).
- Round-robin: req=4'b1111 held with new words after each ack.
  - Grant order 0,1,2,3,0.
  - After reset, req=4'b1010 -> grant 1 then 3.
- Backpressure: hold res_ready=0 for 5 cycles in REPORT.
  - res_valid, res_chan and res_count stay stable.
  - No ack occurs.
  - Next ack no earlier than 1 cycle after acceptance.
- Reset mid-SHIFT (after 3 bits):
  - All outputs return to 0 and no result is produced.
  - A subsequent req[2] frame completes correctly with res_chan=2.
- With SEQ_DETECT_ARBITER_STATS_EN:
  - Three accepted frames with counts 2, 0, 1 -> stat_frames=3, stat_matches=3.
  - Preload near 16'hFFFF (force) -> counters saturate.

Source files
------------

// File: rtl/seq_arb_pkg.sv
// Shared types and constants for the seq_detect_arbiter slice: FSM states,
// default pattern and the saturating statistics-counter helper.
package seq_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      REPORT
   } arbState_t;

   localparam int DEFAULT_PAT_LEN = 4;
   localparam logic [DEFAULT_PAT_LEN-1:0] DEFAULT_PATTERN = 4'b1011;

   localparam int STAT_W = 16;

   // Adds two counter values, clamping at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] satAdd(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
      logic [STAT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[STAT_W] ? '1 : sum[STAT_W-1:0];
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: counts (overlapping) occurrences of PATTERN in the
// bit stream fed since the last clear; history never spans a clear.
module seq_match_core
   import seq_arb_pkg::*;
#(
   parameter int WORD_W = 8,
   parameter int PAT_LEN = DEFAULT_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        bit_valid,
   input  logic                        bit_in,
   output logic [$clog2(WORD_W+1)-1:0] count
);

   localparam int FILL_W = $clog2(PAT_LEN+1);
   localparam int CNT_W  = $clog2(WORD_W+1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

   logic [PAT_LEN-1:0] hist_q, hist_d;
   logic [PAT_LEN:0]   histExt;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [CNT_W-1:0]   count_q, count_d;

   // fill tracks how many frame bits sit in the history, so a partially
   // filled window (zeros left over from the clear) can never match.
   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      count_d = count_q;
      histExt = {hist_q, bit_in};
      if (clear) begin
         hist_d  = '0;
         fill_d  = '0;
         count_d = '0;
      end else if (bit_valid) begin
         hist_d = histExt[PAT_LEN-1:0];
         if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FILL_W'(1);
         end
         if (fill_d == FILL_FULL && hist_d == PATTERN) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hist_q  <= '0;
         fill_q  <= '0;
         count_q <= '0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin shares one serial pattern matcher between NUM_REQ word sources.
// Define SEQ_DETECT_ARBITER_STATS_EN to add the stat_frames/stat_matches counters.
module seq_detect_arbiter
   import seq_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WORD_W = 8,
   parameter int PAT_LEN = DEFAULT_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*WORD_W-1:0]     word_in,
   output logic [NUM_REQ-1:0]            ack,
   output logic                          busy,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [$clog2(NUM_REQ)-1:0]    res_chan,
   output logic [$clog2(WORD_W+1)-1:0]   res_count
`ifdef SEQ_DETECT_ARBITER_STATS_EN
   ,
   output logic [STAT_W-1:0]             stat_frames,
   output logic [STAT_W-1:0]             stat_matches
`endif
);

   localparam int CHAN_W = $clog2(NUM_REQ);
   localparam int CNT_W  = $clog2(WORD_W+1);
   localparam int BIT_W  = CNT_W;
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W-1);
   localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_REQ-1);

   if (PAT_LEN < 1 || PAT_LEN > WORD_W) begin : g_badPatLen
      $error("seq_detect_arbiter: PAT_LEN must lie within 1..WORD_W");
   end
   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_badNumReq
      $error("seq_detect_arbiter: NUM_REQ must lie within 2..16");
   end

   arbState_t          state_q, state_d;
   logic [CHAN_W-1:0]  rr_q, rr_d;
   logic [CHAN_W-1:0]  chan_q, chan_d;
   logic [WORD_W-1:0]  shift_q, shift_d;
   logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;

   logic               grant;
   logic [CHAN_W-1:0]  sel;
   int                 cand;
   logic               matchClear;
   logic               matchValid;
   logic [CNT_W-1:0]   matchCount;

   // First requester at or after the rr pointer wins; reset masks the grant
   // so no ack can escape while the block is being reset.
   always_comb begin
      grant = 1'b0;
      sel   = '0;
      cand  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (int'(rr_q) + i) % NUM_REQ;
         if (!grant && req[cand]) begin
            grant = 1'b1;
            sel   = CHAN_W'(cand);
         end
      end
      grant = grant & ~reset;
   end

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      chan_d     = chan_q;
      shift_d    = shift_q;
      bitCnt_d   = bitCnt_q;
      matchClear = 1'b0;
      matchValid = 1'b0;
      ack        = '0;
      case (state_q)
         IDLE: begin
            if (grant) begin
               ack[sel]   = 1'b1;
               shift_d    = word_in[sel*WORD_W +: WORD_W];
               chan_d     = sel;
               rr_d       = (sel == LAST_CHAN) ? '0 : sel + CHAN_W'(1);
               bitCnt_d   = '0;
               matchClear = 1'b1;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            matchValid = 1'b1;
            shift_d    = shift_q << 1;
            bitCnt_d   = bitCnt_q + BIT_W'(1);
            if (bitCnt_q == LAST_BIT) begin
               state_d = REPORT;
            end
         end
         REPORT: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         rr_q     <= '0;
         chan_q   <= '0;
         shift_q  <= '0;
         bitCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         chan_q   <= chan_d;
         shift_q  <= shift_d;
         bitCnt_q <= bitCnt_d;
      end
   end

   seq_match_core #(
      .WORD_W  (WORD_W),
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) u_match (
      .clock     (clock),
      .reset     (reset),
      .clear     (matchClear),
      .bit_valid (matchValid),
      .bit_in    (shift_q[WORD_W-1]),
      .count     (matchCount)
   );

   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == REPORT);
   assign res_chan  = chan_q;
   assign res_count = matchCount;

`ifdef SEQ_DETECT_ARBITER_STATS_EN
   logic [STAT_W-1:0] statFrames_q, statMatches_q;

   // Counters advance only on an accepted result, clamping at all-ones.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         statFrames_q  <= '0;
         statMatches_q <= '0;
      end else if (res_valid && res_ready) begin
         statFrames_q  <= satAdd(statFrames_q, STAT_W'(1));
         statMatches_q <= satAdd(statMatches_q, STAT_W'(matchCount));
      end
   end

   assign stat_frames  = statFrames_q;
   assign stat_matches = statMatches_q;
`else
   // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Self-checking bench for seq_detect_arbiter: directed frames with literal
// expectations plus randomized traffic checked against a cycle-level model.
module tb_seq_detect_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WORD_W  = 8;
   localparam int PAT_LEN = 4;
   localparam logic [PAT_LEN-1:0] PATTERN = 4'b1011;

   logic                      clock = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*WORD_W-1:0] word_in;
   logic [NUM_REQ-1:0]        ack;
   logic                      busy;
   logic                      res_valid;
   logic                      res_ready;
   logic [1:0]                res_chan;
   logic [3:0]                res_count;
`ifdef SEQ_DETECT_ARBITER_STATS_EN
   logic [15:0]               stat_frames;
   logic [15:0]               stat_matches;
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   seq_detect_arbiter #(
      .NUM_REQ (NUM_REQ),
      .WORD_W  (WORD_W),
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .word_in   (word_in),
      .ack       (ack),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_chan  (res_chan),
      .res_count (res_count)
`ifdef SEQ_DETECT_ARBITER_STATS_EN
      ,
      .stat_frames  (stat_frames),
      .stat_matches (stat_matches)
`endif
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference match count: slide a PAT_LEN window over the MSB-first bit stream.
   function automatic int refCount(input logic [WORD_W-1:0] w);
      bit stream[$];
      logic [PAT_LEN-1:0] pat;
      int n;
      bit hit;
      pat = PATTERN;
      n = 0;
      for (int i = WORD_W-1; i >= 0; i--) stream.push_back(w[i]);
      for (int s = 0; s + PAT_LEN <= stream.size(); s++) begin
         hit = 1'b1;
         for (int j = 0; j < PAT_LEN; j++)
            if (stream[s+j] != pat[PAT_LEN-1-j]) hit = 1'b0;
         if (hit) n++;
      end
      return n;
   endfunction

   function automatic int arbPick(input logic [NUM_REQ-1:0] r, input int rr);
      for (int k = 0; k < NUM_REQ; k++)
         if (r[(rr+k) % NUM_REQ]) return (rr+k) % NUM_REQ;
      return -1;
   endfunction

   // Model: a frame is a grant time plus its channel and reference count;
   // outputs follow from elapsed cycles since the grant.
   bit mActive;
   int mCyc, mAckCyc, mChan, mCount, mRr, mLastChan, mLastCount;
   int mFrames, mMatches;
   int pick, expAck, elapsed;

   task automatic modelReset();
      mActive = 0; mRr = 0; mLastChan = 0; mLastCount = 0;
      mFrames = 0; mMatches = 0;
   endtask

   always @(negedge clock) begin
      if (reset) begin
         checkOutput("reset ack", ack, 0);
         checkOutput("reset busy", busy, 0);
         checkOutput("reset res_valid", res_valid, 0);
         checkOutput("reset res_chan", res_chan, 0);
         checkOutput("reset res_count", res_count, 0);
`ifdef SEQ_DETECT_ARBITER_STATS_EN
         checkOutput("reset stat_frames", stat_frames, 0);
         checkOutput("reset stat_matches", stat_matches, 0);
`endif
         modelReset();
      end else begin
         pick = -1;
         expAck = 0;
         elapsed = mCyc - mAckCyc;
         if (!mActive) begin
            pick = arbPick(req, mRr);
            if (pick >= 0) expAck = 1 << pick;
            checkOutput("model ack", ack, expAck);
            checkOutput("model busy idle", busy, 0);
            checkOutput("model res_valid idle", res_valid, 0);
            checkOutput("model res_chan held", res_chan, mLastChan);
            checkOutput("model res_count held", res_count, mLastCount);
         end else begin
            checkOutput("model ack busy", ack, 0);
            checkOutput("model busy", busy, 1);
            checkOutput("model res_valid", res_valid, (elapsed > WORD_W) ? 1 : 0);
            checkOutput("model res_chan", res_chan, mChan);
            if (elapsed > WORD_W) checkOutput("model res_count", res_count, mCount);
         end
`ifdef SEQ_DETECT_ARBITER_STATS_EN
         checkOutput("model stat_frames", stat_frames, mFrames);
         checkOutput("model stat_matches", stat_matches, mMatches);
`endif
         if (!mActive && pick >= 0) begin
            mActive   = 1;
            mAckCyc   = mCyc;
            mChan     = pick;
            mCount    = refCount(word_in[pick*WORD_W +: WORD_W]);
            mRr       = (pick + 1) % NUM_REQ;
            mLastChan = pick;
         end else if (mActive && elapsed > WORD_W && res_ready) begin
            mActive    = 0;
            mLastCount = mCount;
            mFrames    = (mFrames + 1 > 65535) ? 65535 : mFrames + 1;
            mMatches   = (mMatches + mCount > 65535) ? 65535 : mMatches + mCount;
         end
         mCyc++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic rdy);
      req = r;
      res_ready = rdy;
   endtask

   task automatic waitAck(output int ch);
      ch = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         if (ack != 0) begin
            for (int i = 0; i < NUM_REQ; i++) if (ack[i]) ch = i;
            break;
         end
         tick();
      end
      if (ch < 0) checkOutput("ack wait timeout", 0, 1);
   endtask

   task automatic runFrame(input int ch, input logic [WORD_W-1:0] w,
                           input int expCount, input int stall);
      int got;
      int edges;
      tick();
      word_in[ch*WORD_W +: WORD_W] = w;
      applyStimulus(NUM_REQ'(1) << ch, 1'b0);
      waitAck(got);
      checkOutput("frame grant channel", got, ch);
      tick();
      applyStimulus('0, 1'b0);
      edges = 1;
      while (edges < 30) begin
         @(negedge clock);
         if (res_valid) break;
         tick();
         edges++;
      end
      checkOutput("ack to res_valid edges", edges, WORD_W + 1);
      checkOutput("frame res_chan", res_chan, ch);
      checkOutput("frame res_count", res_count, expCount);
      for (int s = 0; s < stall; s++) begin
         tick();
         applyStimulus('1, 1'b0);
         @(negedge clock);
         checkOutput("stall no ack", ack, 0);
         checkOutput("stall res_valid", res_valid, 1);
         checkOutput("stall res_chan", res_chan, ch);
         checkOutput("stall res_count", res_count, expCount);
      end
      tick();
      applyStimulus('0, 1'b1);
      tick();
      applyStimulus('0, 1'b0);
   endtask

   task automatic pulseReset();
      tick();
      reset = 1'b1;
      applyStimulus('0, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   int grants[5];
   int seen;

   initial begin
      reset = 1'b1;
      req = '0;
      word_in = '0;
      res_ready = 1'b0;

      checkOutput("pin model 10110110", refCount(8'b10110110), 2);
      checkOutput("pin model 00001011", refCount(8'b00001011), 1);

      repeat (2) tick();
      reset = 1'b0;

      runFrame(0, 8'b10110110, 2, 0);
      runFrame(0, 8'hFF, 0, 0);
      runFrame(0, 8'h00, 0, 0);
      runFrame(0, 8'b00001011, 1, 0);
      runFrame(1, 8'b10110110, 2, 5);

      pulseReset();
      word_in = $urandom;
      applyStimulus(4'b1111, 1'b1);
      for (int g = 0; g < 5; g++) begin
         waitAck(grants[g]);
         tick();
         if (grants[g] >= 0) word_in[grants[g]*WORD_W +: WORD_W] = WORD_W'($urandom);
      end
      checkOutput("rr grant 0", grants[0], 0);
      checkOutput("rr grant 1", grants[1], 1);
      checkOutput("rr grant 2", grants[2], 2);
      checkOutput("rr grant 3", grants[3], 3);
      checkOutput("rr grant 4", grants[4], 0);

      pulseReset();
      applyStimulus(4'b1010, 1'b1);
      waitAck(grants[0]);
      tick();
      waitAck(grants[1]);
      tick();
      applyStimulus('0, 1'b1);
      checkOutput("rr 1010 first", grants[0], 1);
      checkOutput("rr 1010 second", grants[1], 3);
      repeat (12) tick();

      word_in[1*WORD_W +: WORD_W] = 8'hFF;
      applyStimulus(4'b0010, 1'b1);
      waitAck(grants[0]);
      tick();
      applyStimulus('0, 1'b1);
      repeat (3) tick();
      reset = 1'b1;
      @(negedge clock);
      checkOutput("mid-frame reset busy", busy, 0);
      checkOutput("mid-frame reset res_chan", res_chan, 0);
      tick();
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (res_valid || ack != 0) seen = 1;
         tick();
      end
      checkOutput("no result after reset", seen, 0);
      runFrame(2, 8'b10110110, 2, 0);

`ifdef SEQ_DETECT_ARBITER_STATS_EN
      pulseReset();
      runFrame(0, 8'b10110110, 2, 0);
      runFrame(1, 8'hFF, 0, 0);
      runFrame(2, 8'b00001011, 1, 0);
      @(negedge clock);
      checkOutput("stat_frames after 3", stat_frames, 3);
      checkOutput("stat_matches after 3", stat_matches, 3);
`endif

      for (int c = 0; c < 3000; c++) begin
         tick();
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 499) == 0) reset = 1'b1;
         if ($urandom_range(0, 3) == 0) req = NUM_REQ'($urandom);
         word_in = $urandom;
         res_ready = ($urandom_range(0, 3) != 0);
      end
      tick();
      reset = 1'b0;
      applyStimulus('0, 1'b1);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      mismatched++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
